// File: rtl/flitzip_pkg.sv
// Shared definitions for the FlitZip packing stage: enable codes, the
// code-to-length map and the packing controller state encoding.
package flitzip_pkg;

    localparam int W_WORD = 128;
    localparam int W_BUF  = 256;
    localparam int W_FILL = 9;

    localparam logic [2:0] EN_0   = 3'b000;
    localparam logic [2:0] EN_128 = 3'b001;
    localparam logic [2:0] EN_32  = 3'b010;
    localparam logic [2:0] EN_48  = 3'b011;
    localparam logic [2:0] EN_64  = 3'b100;
    localparam logic [2:0] EN_80  = 3'b101;
    localparam logic [2:0] EN_96  = 3'b110;
    localparam logic [2:0] EN_112 = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_e;

    function automatic logic [7:0] en_len(input logic [2:0] code);
        logic [7:0] len;
        len = 8'd0;
        case (code)
            EN_0:    len = 8'd0;
            EN_128:  len = 8'd128;
            EN_32:   len = 8'd32;
            EN_48:   len = 8'd48;
            EN_64:   len = 8'd64;
            EN_80:   len = 8'd80;
            EN_96:   len = 8'd96;
            EN_112:  len = 8'd112;
            default: len = 8'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/pack_shift_buf.sv
// 256-bit packing buffer: masked insert of a variable-length payload at the
// current fill level, and a 128-bit right shift when a word leaves.
module pack_shift_buf
    import flitzip_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_len,
    input  logic [W_WORD-1:0] wr_data,
    input  logic              shift_en,
    output logic [W_WORD-1:0] lo_word,
    output logic [W_FILL-1:0] fill
);

    logic [W_BUF-1:0]  buf_q,  buf_d;
    logic [W_FILL-1:0] fill_q, fill_d;

    logic [W_FILL-1:0] shift_amt;
    logic [W_FILL-1:0] wpos;
    logic [W_BUF-1:0]  base;
    logic [W_WORD-1:0] mask;
    logic [W_BUF-1:0]  ins;

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        shift_amt = '0;
        if (shift_en) begin
            shift_amt = (fill_q >= 9'd128) ? 9'd128 : fill_q;
        end
        base   = shift_en ? (buf_q >> W_WORD) : buf_q;
        wpos   = fill_q - shift_amt;
        // A length of 0 shifts the all-ones pattern out entirely.
        mask   = {W_WORD{1'b1}} >> (8'd128 - wr_len);
        ins    = {{W_WORD{1'b0}}, wr_data & mask} << wpos;
        buf_d  = base;
        fill_d = fill_q - shift_amt;
        if (wr_en) begin
            buf_d  = base | ins;
            fill_d = fill_d + {1'b0, wr_len};
        end
    end

    // NOTE: the buffer is reset because bits above the fill level must read as zero padding.
    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    assign lo_word = buf_q[W_WORD-1:0];
    assign fill    = fill_q;

endmodule

// File: rtl/flit_pack_ctrl.sv
// FlitZip packing controller: packs variable-length compressed flits into
// 128-bit words and flushes a zero-padded final word at packet end.
module flit_pack_ctrl
    import flitzip_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_bits,
    output logic              out_last,
    output logic [CNT_W-1:0]  pkt_flits
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              term_q,  term_d;

    logic [W_FILL-1:0] fill;
    logic [7:0]        len;
    logic [W_FILL-1:0] fill_nx;
    logic              in_ready_c, out_valid_c, out_last_c;
    logic [7:0]        out_bits_c;
    logic              accept, emit;

    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_bits_c  = 8'd0;
        out_last_c  = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        term_d      = term_q;

        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
            end
            ACCUM: begin
                in_ready_c  = (fill <= 9'd128);
                out_valid_c = (fill >= 9'd128);
                out_bits_c  = 8'd128;
            end
            FLUSH: begin
                out_valid_c = (fill != 9'd0) | term_q;
                out_bits_c  = (fill >= 9'd128) ? 8'd128 : fill[7:0];
                out_last_c  = (fill <= 9'd128);
            end
            default: ;
        endcase

        len     = en_len(in_en);
        accept  = in_valid & in_ready_c;
        emit    = out_valid_c & out_ready;
        // Emit alongside accept only happens in ACCUM at fill 128, so 128 is the right decrement.
        fill_nx = fill - (emit ? 9'd128 : 9'd0) + {1'b0, len};

        if (accept) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            if (in_last) begin
                state_d = FLUSH;
                term_d  = (fill_nx == 9'd0);
            end else if (state_q == IDLE) begin
                state_d = ACCUM;
            end
        end

        if (emit && out_last_c) begin
            state_d = IDLE;
            cnt_d   = '0;
            term_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            term_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            term_q  <= term_d;
        end
    end

    pack_shift_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (accept),
        .wr_len   (len),
        .wr_data  (in_data),
        .shift_en (emit),
        .lo_word  (out_data),
        .fill     (fill)
    );

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_c;
    assign out_bits  = out_bits_c;
    assign out_last  = out_last_c;
    assign pkt_flits = cnt_q;

endmodule

// File: tb/tb_flit_pack_ctrl.sv
// Directed bench for flit_pack_ctrl: hand-computed packed words, stall,
// terminator, garbage masking and mid-packet reset.
module tb_flit_pack_ctrl;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_en;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [7:0]   out_bits;
    logic         out_last;
    logic [15:0]  pkt_flits;

    typedef struct {
        logic [127:0] d;
        logic [7:0]   b;
        logic         l;
        logic [15:0]  p;
    } word_t;

    word_t q[$];
    int    tests = 0;
    int    fails = 0;

    flit_pack_ctrl #(.DATA_W(128), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_en     (in_en),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bits  (out_bits),
        .out_last  (out_last),
        .pkt_flits (pkt_flits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q.push_back('{out_data, out_bits, out_last, pkt_flits});
        end
        if (rst_n) begin
            check("fill_bound", {127'd0, dut.u_buf.fill <= 9'd256}, 128'd1);
        end
    end

    function automatic logic [127:0] ef(input int k);
        logic [15:0] hi;
        hi = 16'hE000 + 16'(k);
        return {4{hi, 16'h5A5A}};
    endfunction

    task automatic send(input string tag, input logic [2:0] en, input logic [127:0] data,
                        input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_en    = en;
        in_data  = data;
        in_last  = last;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_accept"}, {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [127:0] d, input logic [7:0] b,
                               input logic l, input logic [15:0] p);
        int    n;
        word_t w;
        n = 0;
        while (q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_present"}, {127'd0, q.size() != 0}, 128'd1);
        if (q.size() != 0) begin
            w = q.pop_front();
            check({tag, "_data"}, w.d, d);
            check({tag, "_bits"}, {120'd0, w.b}, {120'd0, b});
            check({tag, "_last"}, {127'd0, w.l}, {127'd0, l});
            if (l) check({tag, "_pkt"}, {112'd0, w.p}, {112'd0, p});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_en     = 3'b000;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {127'd0, in_ready},  128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_last",  {127'd0, out_last},  128'd0);
        check("rst_out_bits",  {120'd0, out_bits},  128'd0);
        check("rst_out_data",  out_data,            128'd0);
        check("rst_pkt",       {112'd0, pkt_flits}, 128'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Four 64-bit flits, with junk above bit 63.
        send("t1_f0", 3'b100, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF}, 1'b0);
        send("t1_f1", 3'b100, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFEDC_BA98_7654_3210}, 1'b0);
        send("t1_f2", 3'b100, {64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_4444}, 1'b0);
        send("t1_f3", 3'b100, {64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_6666_7777_8888}, 1'b1);
        expect_word("t1_w0", 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF, 8'd128, 1'b0, 16'd0);
        expect_word("t1_w1", 128'h5555_6666_7777_8888_1111_2222_3333_4444, 8'd128, 1'b1, 16'd4);
        @(posedge clk); #1;

        // 32 + 48 + 112 = 192 bits.
        send("t2_f0", 3'b010, 128'h0000_0000_0000_0000_0000_0000_AAAA_0001, 1'b0);
        send("t2_f1", 3'b011, 128'h0000_0000_0000_0000_0000_BBBB_0000_0002, 1'b0);
        send("t2_f2", 3'b111, 128'h0000_CCCC_1111_2222_3333_4444_5555_6666, 1'b1);
        expect_word("t2_w0", 128'h4444_5555_6666_BBBB_0000_0002_AAAA_0001, 8'd128, 1'b0, 16'd0);
        expect_word("t2_w1", 128'h0000_0000_0000_0000_CCCC_1111_2222_3333, 8'd64,  1'b1, 16'd3);
        @(posedge clk); #1;

        // Empty terminator.
        send("t3_f0", 3'b000, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1);
        expect_word("t3_w0", 128'd0, 8'd0, 1'b1, 16'd1);
        @(posedge clk); #1;

        // Ones above the payload must not leak into the packed word.
        send("t5_f0", 3'b010, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_CAFE_F00D, 1'b0);
        send("t5_f1", 3'b011, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_0123_4567_89AB, 1'b1);
        expect_word("t5_w0", 128'h0000_0000_0000_0123_4567_89AB_CAFE_F00D, 8'd80, 1'b1, 16'd2);
        @(posedge clk); #1;

        // Back-to-back 128-bit flits, then a 5-cycle output stall.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_en    = 3'b001;
            in_data  = ef(k);
            in_last  = 1'b0;
            check("t4_no_bubble", {127'd0, in_ready}, 128'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        in_data   = ef(4);
        check("t4_accept_at_128", {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;
        in_data = ef(5);
        in_last = 1'b1;
        for (int s = 0; s < 5; s++) begin
            check("t4_stall_in_ready",  {127'd0, in_ready},  128'd0);
            check("t4_stall_out_valid", {127'd0, out_valid}, 128'd1);
            check("t4_stall_data",      out_data,            ef(3));
            check("t4_stall_bits",      {120'd0, out_bits},  128'd128);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (!in_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            check("t4_resume", {127'd0, in_ready}, 128'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            expect_word("t4_w", ef(k), 8'd128, 1'b0, 16'd0);
        end
        expect_word("t4_wl", ef(5), 8'd128, 1'b1, 16'd6);
        @(posedge clk); #1;

        // Reset with 96 bits buffered.
        send("t6_f0", 3'b110, 128'h0000_0000_9999_8888_7777_6666_5555_4444, 1'b0);
        rst_n = 1'b0;
        #2;
        check("t6_in_ready",  {127'd0, in_ready},  128'd1);
        check("t6_out_valid", {127'd0, out_valid}, 128'd0);
        check("t6_out_last",  {127'd0, out_last},  128'd0);
        check("t6_out_bits",  {120'd0, out_bits},  128'd0);
        check("t6_out_data",  out_data,            128'd0);
        check("t6_pkt",       {112'd0, pkt_flits}, 128'd0);
        check("t6_no_word",   128'(q.size()),      128'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send("t6_f1", 3'b100, 128'hFFFF_FFFF_FFFF_FFFF_0F0F_0F0F_1234_5678, 1'b0);
        send("t6_f2", 3'b010, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_9ABC_DEF0, 1'b1);
        expect_word("t6_w0", 128'h0000_0000_9ABC_DEF0_0F0F_0F0F_1234_5678, 8'd96, 1'b1, 16'd2);
        repeat (3) @(posedge clk);
        #1;
        check("final_no_extra", 128'(q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
